// File: rtl/tarot_pkg.sv
// Shared constants, state encoding and helpers for the tarot spread sequencer.
// Card indices are 7 bits wide; spreads hold at most 8 slots.
package tarot_pkg;

    localparam int          DECK_SIZE    = 78;
    localparam int          CARD_W       = 7;
    localparam int          SLOT_W       = 3;
    localparam logic [15:0] SEED_NONZERO = 16'h0001;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_CHECK  = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    // The Henon PRNG locks up on an all-zero seed, so zero is never handed to it.
    function automatic logic [15:0] nonzero_seed(input logic [15:0] s);
        return (s == 16'h0000) ? SEED_NONZERO : s;
    endfunction

endpackage

// File: rtl/tarot_card_filter.sv
// Combinational sample filter: a raw 7-bit sample becomes a card only if it
// names a real card that has not already been dealt in this spread.
module tarot_card_filter #(
    parameter int DECK = tarot_pkg::DECK_SIZE
) (
    input  logic [tarot_pkg::CARD_W-1:0] idx,
    input  logic [DECK-1:0]              mask,
    output logic                         accept
);
    import tarot_pkg::*;

    // Zero-extended so every 7-bit sample indexes a defined bit.
    logic [2**CARD_W-1:0] mask_ext;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mask_ext            = '0;
        mask_ext[DECK-1:0]  = mask;
        accept              = ({1'b0, idx} < (CARD_W + 1)'(DECK)) && !mask_ext[idx];
    end

endmodule

// File: rtl/tarot_draw_sequencer.sv
// Deals one spread of SPREAD_LEN distinct cards by driving a single Henon PRNG,
// rejection-sampling its x output and taking card orientation from y[0].
module tarot_draw_sequencer #(
    parameter int DECK_SIZE   = tarot_pkg::DECK_SIZE,
    parameter int SPREAD_LEN  = 3,
    parameter int MAX_RETRY   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         draw_req,
    input  logic [15:0]                  seed_q16,
    input  logic [31:0]                  fingerprint_mean,
    output logic                         prng_start,
    output logic [15:0]                  prng_seed_q16,
    output logic [31:0]                  prng_fingerprint,
    input  logic [31:0]                  prng_x,
    input  logic [31:0]                  prng_y,
    input  logic                         prng_done,
    output logic                         card_valid,
    output logic [tarot_pkg::CARD_W-1:0] card_idx,
    output logic                         card_reversed,
    output logic [tarot_pkg::SLOT_W-1:0] card_slot,
    output logic                         spread_done,
    output logic                         busy,
    output logic                         error
);
    import tarot_pkg::*;

    localparam int                RETRY_W   = $clog2(MAX_RETRY + 1);
    localparam int                TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SPREAD_LEN - 1);

    state_t               state;
    state_t               state_nx;
    logic [DECK_SIZE-1:0] mask;
    logic [SLOT_W-1:0]    slot;
    logic [RETRY_W-1:0]   retry;
    logic [TMO_W-1:0]     tmo_cnt;
    logic [15:0]          seed;
    logic [31:0]          fingerprint;
    logic [15:0]          x_lat;
    logic                 y_lat;
    logic [CARD_W-1:0]    idx;
    logic                 accept_card;
    logic                 unused_bits;

    assign idx              = x_lat[CARD_W-1:0];
    assign prng_seed_q16    = seed;
    assign prng_fingerprint = fingerprint;
    assign unused_bits      = ^{prng_x[31:16], prng_y[31:1]};

    tarot_card_filter #(
        .DECK (DECK_SIZE)
    ) u_filter (
        .idx    (idx),
        .mask   (mask),
        .accept (accept_card)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        prng_start  = 1'b0;
        card_valid  = 1'b0;
        spread_done = 1'b0;
        busy        = 1'b1;
        error       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (draw_req) state_nx = S_LAUNCH;
            end
            S_ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (draw_req) state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                prng_start = 1'b1;
                state_nx   = S_WAIT;
            end
            // A result arriving on the final timeout cycle is still taken.
            S_WAIT: begin
                if (prng_done)                                state_nx = S_CHECK;
                else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) state_nx = S_ERR;
            end
            S_CHECK: begin
                if (accept_card)                              state_nx = S_EMIT;
                else if (retry == RETRY_W'(MAX_RETRY - 1))    state_nx = S_ERR;
                else                                          state_nx = S_LAUNCH;
            end
            S_EMIT: begin
                card_valid = 1'b1;
                state_nx   = (slot == LAST_SLOT) ? S_DONE : S_LAUNCH;
            end
            S_DONE: begin
                spread_done = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: the dealt-card mask is a plain register, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask          <= '0;
            slot          <= '0;
            retry         <= '0;
            tmo_cnt       <= '0;
            seed          <= '0;
            fingerprint   <= '0;
            x_lat         <= '0;
            y_lat         <= 1'b0;
            card_idx      <= '0;
            card_reversed <= 1'b0;
            card_slot     <= '0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (draw_req) begin
                        seed        <= nonzero_seed(seed_q16);
                        fingerprint <= fingerprint_mean;
                        mask        <= '0;
                        slot        <= '0;
                        retry       <= '0;
                    end
                end
                S_LAUNCH: tmo_cnt <= '0;
                S_WAIT: begin
                    if (prng_done) begin
                        x_lat <= prng_x[15:0];
                        y_lat <= prng_y[0];
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                // Every sample chains the next seed, whether or not it became a card.
                S_CHECK: begin
                    seed <= nonzero_seed(x_lat);
                    if (accept_card) begin
                        card_idx      <= idx;
                        card_reversed <= y_lat;
                        card_slot     <= slot;
                    end else begin
                        retry <= retry + RETRY_W'(1);
                    end
                end
                S_EMIT: begin
                    mask  <= mask | (DECK_SIZE'(1) << card_idx);
                    retry <= '0;
                    if (slot != LAST_SLOT) slot <= slot + SLOT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
